// File: rtl/sr_latch_ctrl_pkg.sv
// Shared types and constants for the SR latch bank sequencer.
package sr_latch_ctrl_pkg;

  // FSM state encodings
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_CHECK = 2'd3
  } state_e;

  // Command op codes
  localparam logic OP_SET = 1'b1;
  localparam logic OP_RST = 1'b0;

  // Requester identifiers as reported on last_grant
  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  // One-hot grant from the two-requester arbiter
  typedef struct packed {
    logic a;
    logic b;
  } grant_t;

  // Index width for an N-entry bank, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of a down-counter that holds 0 .. m-1
  function automatic int cnt_width(input int m);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/sr_latch_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; grants only while enabled.
module rr_arb2
  import sr_latch_ctrl_pkg::*;
(
  input  logic   en,
  input  logic   a_valid,
  input  logic   b_valid,
  input  logic   last_grant,
  output grant_t grant
);

  // On a tie, hand the grant to whichever requester was not served last
  always_comb begin
    grant = '0;
    if (en) begin
      if (a_valid && b_valid) begin
        if (last_grant == GRANT_A) grant.b = 1'b1;
        else                       grant.a = 1'b1;
      end else if (a_valid) begin
        grant.a = 1'b1;
      end else if (b_valid) begin
        grant.b = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Sequencer for a bank of NOR SR latches: arbitrates two command sources,
// drives a timed S or R pulse, waits a dead-time, then checks the readback.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | waiting for a command; ready asserted to the granted source
//  ST_PULSE | S or R of the selected latch held high for PULSE_W cycles
//  ST_GAP   | all S/R low for GAP_W cycles so the latch settles
//  ST_CHECK | one cycle: done pulses, readback compared against op
module sr_latch_ctrl
  import sr_latch_ctrl_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int PULSE_W = 2,
  parameter  int GAP_W   = 1,
  localparam int IDX_W   = idx_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic             a_op,
  input  logic [IDX_W-1:0] a_idx,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic             b_op,
  input  logic [IDX_W-1:0] b_idx,
  output logic [N-1:0]     s,
  output logic [N-1:0]     r,
  input  logic [N-1:0]     q_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             last_grant
);

  // One counter serves both the pulse and the gap phase
  localparam int CNT_MAX = max2(PULSE_W, GAP_W);
  localparam int CNT_W   = cnt_width(CNT_MAX);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             oor_q, oor_d;
  logic             last_grant_q, last_grant_d;
  logic             err_q, err_d;
  logic [N-1:0]     s_q, s_d;
  logic [N-1:0]     r_q, r_d;

  grant_t           grant;
  logic             arb_en;
  logic             q_sel;
  logic             check_fail;
  logic [IDX_W-1:0] cmd_idx;
  logic             cmd_op;

  assign arb_en = (state_q == ST_IDLE);

  rr_arb2 u_arb (
    .en         (arb_en),
    .a_valid    (a_valid),
    .b_valid    (b_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Command fields of whichever requester wins this cycle
  assign cmd_idx = grant.b ? b_idx : a_idx;
  assign cmd_op  = grant.b ? b_op  : a_op;

  // State and datapath registers; reset pulls every latch drive low at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op_q         <= OP_RST;
      idx_q        <= '0;
      oor_q        <= 1'b0;
      last_grant_q <= GRANT_B;
      err_q        <= 1'b0;
      s_q          <= '0;
      r_q          <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      idx_q        <= idx_d;
      oor_q        <= oor_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      s_q          <= s_d;
      r_q          <= r_d;
    end
  end

  // Next-state logic: accept, count down the pulse, count down the gap, check
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    idx_d        = idx_q;
    oor_d        = oor_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant.a || grant.b) begin
          state_d      = ST_PULSE;
          cnt_d        = CNT_W'(PULSE_W - 1);
          op_d         = cmd_op;
          idx_d        = cmd_idx;
          oor_d        = (int'(cmd_idx) >= N);
          last_grant_d = grant.b ? GRANT_B : GRANT_A;
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = CNT_W'(GAP_W - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_CHECK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (check_fail) err_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch drive for the next cycle: at most one bit, only while pulsing,
  // and never for an index outside the bank
  always_comb begin
    s_d = '0;
    r_d = '0;
    if (state_d == ST_PULSE && !oor_d) begin
      for (int i = 0; i < N; i++) begin
        if (int'(idx_d) == i) begin
          if (op_d == OP_SET)      s_d[i] = 1'b1;
          else if (op_d == OP_RST) r_d[i] = 1'b1;
        end
      end
    end
  end

  // Outputs: handshake, status, and the readback comparison made in CHECK
  always_comb begin
    q_sel = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (int'(idx_q) == i) q_sel = q_in[i];
    end
    check_fail = (state_q == ST_CHECK) && (oor_q || (q_sel != op_q));
    a_ready    = grant.a;
    b_ready    = grant.b;
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_CHECK);
    err        = err_q | check_fail;
    last_grant = last_grant_q;
  end

  assign s = s_q;
  assign r = r_q;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Bench for sr_latch_ctrl with a 3-latch bank (index 3 is out of range).
module tb_sr_latch_ctrl;

  localparam int N  = 3;
  localparam int PW = 2;
  localparam int GW = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         a_valid = 1'b0, a_op = 1'b0;
  logic         b_valid = 1'b0, b_op = 1'b0;
  logic [1:0]   a_idx = 2'd0, b_idx = 2'd0;
  logic         a_ready, b_ready, busy, done, err, last_grant;
  logic [N-1:0] s, r, q_in;
  logic [N-1:0] bank_q = '0;
  logic [N-1:0] stuck = '0;

  always #5 clk = ~clk;

  // Behavioural NOR latch bank; stuck bits force the readback low
  always @(s, r) begin
    for (int i = 0; i < N; i++) begin
      if (s[i] && !r[i])      bank_q[i] = 1'b1;
      else if (r[i] && !s[i]) bank_q[i] = 1'b0;
    end
  end
  assign q_in = bank_q & ~stuck;

  sr_latch_ctrl #(.N(N), .PULSE_W(PW), .GAP_W(GW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_idx(a_idx),
    .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_idx(b_idx),
    .s(s), .r(r), .q_in(q_in),
    .busy(busy), .done(done), .err(err), .last_grant(last_grant)
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, done_cyc = 0;

  // Reference model: a command is a timeline counted from its accept
  bit           m_active = 0, m_op = 0, m_last = 1, m_err = 0;
  int           m_age = 0, m_idx = 0;
  logic [N-1:0] m_q = '0;
  bit           g_a = 0, g_b = 0, obs_a = 0, obs_b = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: called at a negedge with inputs already driven
  task automatic cycle();
    logic [N-1:0] es, er, qe;
    bit ebusy, edone, eerr, ea, eb, mm;
    #1;
    es = '0; er = '0; ebusy = 0; edone = 0; eerr = m_err; ea = 0; eb = 0;
    if (m_active) begin
      ebusy = 1;
      if (m_age <= PW) begin
        if (m_idx < N) begin
          if (m_op) es[m_idx] = 1'b1;
          else      er[m_idx] = 1'b1;
        end
      end else if (m_age == PW + GW + 1) begin
        edone = 1;
        qe = m_q & ~stuck;
        if (m_idx >= N) mm = 1;
        else            mm = (qe[m_idx] != m_op);
        eerr = m_err | mm;
      end
    end else if (a_valid && b_valid) begin
      if (m_last) ea = 1; else eb = 1;
    end else begin
      ea = a_valid;
      eb = b_valid;
    end
    chk("s", 32'(s), 32'(es));
    chk("r", 32'(r), 32'(er));
    chk("s_and_r", 32'(s & r), 32'd0);
    chk("onehot", 32'($countones(s | r) <= 1), 32'd1);
    chk("busy", 32'(busy), 32'(ebusy));
    chk("done", 32'(done), 32'(edone));
    chk("err", 32'(err), 32'(eerr));
    chk("a_ready", 32'(a_ready), 32'(ea));
    chk("b_ready", 32'(b_ready), 32'(eb));
    chk("last_grant", 32'(last_grant), 32'(m_last));
    obs_a = a_ready;
    obs_b = b_ready;
    if (done === 1'b1) done_cyc = cyc;
    if (ea || eb) acc_cyc = cyc;
    @(posedge clk);
    if (ea || eb) begin
      m_active = 1; m_age = 1;
      m_op  = ea ? a_op : b_op;
      m_idx = int'(ea ? a_idx : b_idx);
      m_last = eb;
    end else if (m_active) begin
      if (m_age == 1 && m_idx < N) m_q[m_idx] = m_op;
      if (m_age == PW + GW + 1) begin
        m_err = eerr;
        m_active = 0;
      end else begin
        m_age++;
      end
    end
    g_a = ea;
    g_b = eb;
    cyc++;
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_active = 0; m_last = 1; m_err = 0; m_age = 0;
    g_a = 0; g_b = 0;
  endtask

  task automatic do_reset();
    a_valid = 0; b_valid = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic drain();
    int n = 0;
    while (m_active && n < 20) begin
      cycle();
      n++;
    end
    chk("drain_bound", 32'(m_active), 32'd0);
  endtask

  task automatic issue(input bit req_b, input bit op, input logic [1:0] idx);
    int n = 0;
    if (req_b) begin b_valid = 1; b_op = op; b_idx = idx; end
    else       begin a_valid = 1; a_op = op; a_idx = idx; end
    do begin
      cycle();
      n++;
    end while (!(req_b ? g_b : g_a) && n < 20);
    chk("granted", 32'(req_b ? obs_b : obs_a), 32'd1);
    if (req_b) b_valid = 0; else a_valid = 0;
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Reset values
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_last_grant", 32'(last_grant), 32'd1);
    cycle();

    // Set then reset latch 2
    issue(0, 1, 2'd2);
    chk("set_q2", 32'(bank_q[2]), 32'd1);
    chk("set_done_lat", 32'(done_cyc - acc_cyc), 32'(PW + GW + 1));
    chk("set_err", 32'(err), 32'd0);
    issue(0, 0, 2'd2);
    chk("rst_q2", 32'(bank_q[2]), 32'd0);
    chk("rst_done_lat", 32'(done_cyc - acc_cyc), 32'(PW + GW + 1));
    chk("rst_cmd_err", 32'(err), 32'd0);

    // Back-to-back accepts at the minimum spacing
    a_valid = 1; a_op = 1; a_idx = 2'd0;
    repeat (3 * (PW + GW + 2)) cycle();
    a_valid = 0;
    drain();

    // Continuous contention after reset: A first, then alternate
    do_reset();
    a_valid = 1; a_op = 1; a_idx = 2'd0;
    b_valid = 1; b_op = 1; b_idx = 2'd1;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      do begin
        cycle();
        n++;
      end while (!(g_a || g_b) && n < 20);
      chk("rr_a_ready", 32'(obs_a), 32'((k % 2) == 0));
      chk("rr_b_ready", 32'(obs_b), 32'((k % 2) == 1));
      chk("rr_last_grant", 32'(last_grant), 32'(k % 2));
    end
    a_valid = 0; b_valid = 0;
    drain();

    // Readback mismatch is sticky until reset
    do_reset();
    stuck = 3'b010;
    issue(0, 1, 2'd1);
    chk("mm_err", 32'(err), 32'd1);
    stuck = '0;
    issue(1, 1, 2'd0);
    issue(0, 0, 2'd0);
    chk("mm_err_sticky", 32'(err), 32'd1);
    do_reset();
    cycle();
    chk("mm_err_cleared", 32'(err), 32'd0);

    // Reset during the second pulse cycle
    a_valid = 1; a_op = 1; a_idx = 2'd0;
    cycle();
    a_valid = 0;
    cycle();
    #1;
    chk("mid_pre_s", 32'(s), 32'b001);
    rst = 1;
    #1;
    chk("mid_s", 32'(s), 32'd0);
    chk("mid_r", 32'(r), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 0;
    model_reset();
    repeat (PW + GW + 2) cycle();

    // Out-of-range index walks the sequence with no drive and flags err
    issue(1, 1, 2'd3);
    chk("oor_err", 32'(err), 32'd1);
    chk("oor_done_lat", 32'(done_cyc - acc_cyc), 32'(PW + GW + 1));
    chk("oor_bank", 32'(bank_q), 32'(m_q));
    do_reset();

    // Random back-to-back commands; requesters hold until granted
    for (int c = 0; c < 1000; c++) begin
      if (!a_valid || g_a) begin
        a_valid = 1'($urandom_range(0, 1));
        a_op    = 1'($urandom_range(0, 1));
        a_idx   = 2'($urandom_range(0, 3));
      end
      if (!b_valid || g_b) begin
        b_valid = 1'($urandom_range(0, 1));
        b_op    = 1'($urandom_range(0, 1));
        b_idx   = 2'($urandom_range(0, 3));
      end
      cycle();
    end
    a_valid = 0; b_valid = 0;
    drain();
    chk("rand_bank", 32'(bank_q), 32'(m_q));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
